lsu_apb_master: RTL
===================

// Module: lsu_apb_master
// PURPOSE
//  Load/store-unit side of the data-memory APB link; the initiator feeding the word-wide, byte-masked data memory.
//  Accepts one RV32 load/store at a time from the core, checks alignment, and issues one APB3/APB4 transfer.
//  Stores: builds pstrb and lane-replicated pwdata. Loads: extracts the byte/half lane and sign/zero-extends it.
//  Sits between the core's memory stage and data_memory (or any APB slave on the same bus).
// PARAMETERS
//  ADDR_W       11  APB address width (byte address), matches data-memory DMEM_W
//  TIMEOUT_CYC  16  max ACCESS cycles with pready=0 before abort (used only with LSU_APB_TIMEOUT_EN)
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       core request valid
//  req_ready   out  1       block idle, request accepted when valid&ready
//  req_we      in   1       1=store, 0=load
//  req_funct3  in   3       RV32 funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-aligned
//  rsp_valid   out  1       one-cycle completion pulse, no backpressure
//  rsp_rdata   out  32      extended load data (0 for stores/errors)
//  rsp_err     out  1       misaligned, illegal funct3, pslverr or timeout
//  psel        out  1       APB select
//  penable     out  1       APB enable
//  pwrite      out  1       APB write
//  paddr       out  ADDR_W  APB byte address = req_addr[ADDR_W-1:0]
//  pwdata      out  32      APB write data
//  pstrb       out  4       APB byte strobes, 4'b0000 on reads
//  prdata      in   32      APB read data
//  pready      in   1       APB ready
//  pslverr     in   1       APB slave error, sampled with pready
// BEHAVIOUR
//  - Reset: state IDLE. psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata and rsp_err all 0. req_ready=1 after reset.
//  - FSM IDLE->SETUP->ACCESS->IDLE. req_ready = (state==IDLE). On accept, all request fields are registered.
//  - Legal accept: next cycle is SETUP (psel=1, penable=0). The cycle after is ACCESS (penable=1).
//    ACCESS repeats while pready=0. pready=1 -> IDLE.
//    paddr, pwrite, pwdata and pstrb are stable from SETUP through the final ACCESS cycle.
//  - Illegal accept: no APB transfer; state stays IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    Illegal = H with addr[0]!=0; W with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >010.
//  - Store lanes: off=addr[1:0].
//    SB: pstrb = 4'b0001<<off; pwdata = {4{wdata[7:0]}}.
//    SH: pstrb = 4'b0011<<off; pwdata = {2{wdata[15:0]}}.
//    SW: pstrb = 4'b1111; pwdata = wdata.
//  - Load: prdata is shifted right by 8*off, then sign-extended (LB/LH), zero-extended (LBU/LHU) or passed through (LW).
//  - Completion: rsp_valid pulses in the cycle after the pready=1 edge. rsp_err=pslverr. rsp_rdata=0 on error or store.
//    Latency with zero wait states: accept in cycle N, SETUP N+1, ACCESS N+2, rsp_valid and req_ready both high in N+3.
//    A new request may be accepted in that same cycle.
//  - Reset mid-transfer: transfer abandoned, psel=0 next cycle, no rsp_valid ever issued for it.
//  - rsp_valid is never high for two consecutive cycles from a single request.
// CONFIGURATION
//  `LSU_APB_TIMEOUT_EN defined:
//    - An ACCESS-cycle counter increments each cycle pready=0 and clears on accept.
//    - When the count reaches TIMEOUT_CYC: psel and penable drop next cycle, state goes to IDLE, and rsp_valid=1 with rsp_err=1.
//  Not defined: ACCESS waits indefinitely for pready; no counter is built; TIMEOUT_CYC is unused.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101).
//  lsu_pkg: typedef enum logic [1:0] apb_state_e {ST_IDLE, ST_SETUP, ST_ACCESS}.
//  Sub-module lsu_load_align: combinational lane select and extend (prdata, off, funct3 -> rdata).
//  FSM, store lane builder and response registers stay in the top module.
// TESTING
//  1. SW addr 0x010, wdata 0xDEADBEEF, pready=1.
//     -> SETUP psel=1 penable=0 paddr=0x010 pstrb=4'b1111 pwdata=0xDEADBEEF; rsp_valid at N+3, err=0.
//  2. SB addr 0x013, wdata 0x000000A5 -> pstrb=4'b1000, pwdata=0xA5A5A5A5, pwrite=1.
//  3. prdata=0x1280FF00 for all loads:
//     LB 0x002 -> rsp_rdata=0xFFFFFF80; LBU 0x002 -> 0x00000080; LH 0x002 -> 0x00001280; LW 0x000 -> 0x1280FF00.
//  4. LW addr 0x006 -> psel stays 0; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  5. pready=0 for 3 ACCESS cycles -> paddr, pwdata and pstrb stable, penable=1 throughout; rsp_valid 1 cycle after pready.
//     Repeat with pslverr=1 -> rsp_err=1, rsp_rdata=0.
//  6. Macro on, TIMEOUT_CYC=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1.
//     Reset asserted mid-ACCESS -> psel=0 next cycle, no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store-unit APB master: funct3 encodings,
// APB FSM state type and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

    // Illegal requests never reach the bus: bad funct3 for the direction, or misaligned access.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        if (we) begin
            bad_f3 = (f3 > F3_W);
        end else begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        end
        misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane select: shifts the addressed byte/half down to bit 0 and
// sign- or zero-extends it according to the load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] prdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = prdata_i >> {off_i, 3'b000};
        rdata_o = 32'h0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_o = shifted;
            F3_BU:   rdata_o = {24'h0, shifted[7:0]};
            F3_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_apb_master.sv
// RV32 load/store unit APB master: one request at a time, alignment check,
// store lane building, load extension. Optional ACCESS timeout via `LSU_APB_TIMEOUT_EN.
module lsu_apb_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic [3:0]        pstrb,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        state_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [31:0]       pwdata_q;
    logic [3:0]        pstrb_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic [31:0]       pwdata_d;
    logic [3:0]        pstrb_d;
    logic              illegal_d;
    logic [31:0]       load_rdata;

    // Upper request address bits lie outside the data-memory window.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W];

`ifdef LSU_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign illegal_d = req_illegal(req_we, req_funct3, req_addr[1:0]);

    always_comb begin
        pstrb_d  = 4'b0000;
        pwdata_d = 32'h0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    pstrb_d  = 4'b0001 << req_addr[1:0];
                    pwdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    pstrb_d  = 4'b0011 << req_addr[1:0];
                    pwdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    pstrb_d  = 4'b1111;
                    pwdata_d = req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .prdata_i (prdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .rdata_o  (load_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= 32'h0;
            pstrb_q     <= 4'b0000;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
`ifdef LSU_APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (illegal_d) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q  <= ST_SETUP;
                            psel_q   <= 1'b1;
                            pwrite_q <= req_we;
                            paddr_q  <= req_addr[ADDR_W-1:0];
                            pwdata_q <= pwdata_d;
                            pstrb_q  <= pstrb_d;
                            funct3_q <= req_funct3;
                            off_q    <= req_addr[1:0];
`ifdef LSU_APB_TIMEOUT_EN
                            cnt_q    <= '0;
`endif
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= pslverr;
                        rsp_rdata_q <= (pwrite_q || pslverr) ? 32'h0 : load_rdata;
`ifdef LSU_APB_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q     <= ST_IDLE;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
